// File: rtl/temp_sense_pkg.sv
// temp_sense_pkg: shared state encoding, widths and default thresholds for TSD sequencing
package temp_sense_pkg;
   localparam int TS_W    = 8;
   localparam int TIMER_W = 20;
   localparam int SUM_W   = 10;
   localparam logic [TS_W-1:0] OFFSET_DEFAULT   = 8'd133;
   localparam logic [TS_W-1:0] ALARM_HI_DEFAULT = 8'd85;
   localparam logic [TS_W-1:0] ALARM_LO_DEFAULT = 8'd80;
   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WAIT,
      S_CAPTURE,
      S_REPORT
   } ts_state_e;
endpackage

// File: rtl/temp_sense_sched_avg4.sv
// temp_avg4: 4-sample running average; the first sample after reset fills the whole history
module temp_avg4
   import temp_sense_pkg::*;
(
   input  logic            clk,
   input  logic            arst,
   input  logic            load,
   input  logic [TS_W-1:0] sample,
   output logic [TS_W-1:0] avg
);
   logic [TS_W-1:0]  hist_q [4];
   logic [SUM_W-1:0] sum_q;
   logic             full_q;
   // shift history and keep the sum incrementally; preload every slot while empty
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         hist_q <= '{default: '0};
         sum_q  <= '0;
         full_q <= 1'b0;
      end else if (load) begin
         full_q    <= 1'b1;
         hist_q[0] <= sample;
         hist_q[1] <= full_q ? hist_q[0] : sample;
         hist_q[2] <= full_q ? hist_q[1] : sample;
         hist_q[3] <= full_q ? hist_q[2] : sample;
         sum_q     <= full_q ? sum_q - SUM_W'(hist_q[3]) + SUM_W'(sample) : {sample, 2'b00};
      end
   end
   assign avg = sum_q[SUM_W-1:2];
endmodule

// File: rtl/temp_sense_sched.sv
// temp_sense_sched: sequences TSD conversions with timeout/retry, scales, averages and raises over-temp
module temp_sense_sched
   import temp_sense_pkg::*;
#(
   parameter logic [TIMER_W-1:0] PERIOD_CYCLES  = 20'd1048575,
   parameter int                 CLR_CYCLES     = 16,
   parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 20'd524288,
   parameter int                 MAX_RETRY      = 2,
   parameter logic [TS_W-1:0]    OFFSET_DEGREES = OFFSET_DEFAULT,
   parameter logic [TS_W-1:0]    ALARM_HI       = ALARM_HI_DEFAULT,
   parameter logic [TS_W-1:0]    ALARM_LO       = ALARM_LO_DEFAULT
) (
   input  logic            clk,
   input  logic            arst,
   input  logic            enable,
   input  logic            sample_req,
   output logic            busy,
   output logic            tsd_clr,
   input  logic            tsd_done,
   input  logic [TS_W-1:0] tsd_out,
   output logic [TS_W-1:0] degrees_c,
   output logic [TS_W-1:0] degrees_c_avg,
   output logic            fresh_sample,
   output logic            failed_sample,
   output logic            over_temp
);
   localparam logic [TIMER_W-1:0] PER_LAST  = PERIOD_CYCLES - TIMER_W'(1);
   localparam logic [TIMER_W-1:0] CLR_LAST  = TIMER_W'(CLR_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TO_LAST   = TIMEOUT_CYCLES - TIMER_W'(1);
   localparam logic [1:0]         RETRY_MAX = 2'(MAX_RETRY);
   ts_state_e          state_q;
   logic [TIMER_W-1:0] per_q, cnt_q;
   logic [1:0]         retry_q, sync_q;
   logic               pend_q, clr_q, busy_q, fresh_q, failed_q, ot_q, have_q;
   logic [TS_W-1:0]    raw_q, deg_d;
   logic               tick, start, done_s;
   assign tick   = enable && (per_q == PER_LAST);
   assign start  = pend_q || tick || sample_req;
   assign done_s = sync_q[1];
   assign deg_d  = tsd_out - OFFSET_DEGREES;
   // free-running period counter, parked at zero while disabled
   always_ff @(posedge clk or posedge arst) begin
      if (arst) per_q <= '0;
      else      per_q <= (!enable || tick) ? '0 : per_q + TIMER_W'(1);
   end
   // tsd_done comes from the analog block's own timing domain
   always_ff @(posedge clk or posedge arst) begin
      if (arst) sync_q <= '0;
      else      sync_q <= {sync_q[0], tsd_done};
   end
   // conversion sequencer with registered strobes; requests while busy fold into pend_q
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         retry_q  <= '0;
         pend_q   <= 1'b0;
         clr_q    <= 1'b0;
         busy_q   <= 1'b0;
         fresh_q  <= 1'b0;
         failed_q <= 1'b0;
         ot_q     <= 1'b0;
         have_q   <= 1'b0;
         raw_q    <= '0;
      end else begin
         fresh_q  <= 1'b0;
         failed_q <= 1'b0;
         pend_q   <= start;
         case (state_q)
            S_IDLE: if (start) begin
               pend_q  <= 1'b0;
               state_q <= S_CLEAR;
               cnt_q   <= '0;
               retry_q <= '0;
               clr_q   <= 1'b1;
               busy_q  <= 1'b1;
            end
            S_CLEAR: if (cnt_q == CLR_LAST) begin
               state_q <= S_WAIT;
               cnt_q   <= '0;
               clr_q   <= 1'b0;
            end else cnt_q <= cnt_q + TIMER_W'(1);
            S_WAIT: if (done_s) state_q <= S_CAPTURE;
            else if (cnt_q == TO_LAST) begin
               cnt_q <= '0;
               if (retry_q == RETRY_MAX) begin
                  failed_q <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
               end else begin
                  retry_q <= retry_q + 2'd1;
                  clr_q   <= 1'b1;
                  state_q <= S_CLEAR;
               end
            end else cnt_q <= cnt_q + TIMER_W'(1);
            S_CAPTURE: begin
               raw_q   <= tsd_out;
               have_q  <= 1'b1;
               ot_q    <= (deg_d >= ALARM_HI) ? 1'b1 : (deg_d < ALARM_LO) ? 1'b0 : ot_q;
               fresh_q <= 1'b1;
               state_q <= S_REPORT;
            end
            S_REPORT: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               clr_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
   temp_avg4 u_avg (
      .clk    (clk),
      .arst   (arst),
      .load   (state_q == S_CAPTURE),
      .sample (deg_d),
      .avg    (degrees_c_avg)
   );
   assign degrees_c     = have_q ? raw_q - OFFSET_DEGREES : '0;
   assign busy          = busy_q;
   assign tsd_clr       = clr_q;
   assign fresh_sample  = fresh_q;
   assign failed_sample = failed_q;
   assign over_temp     = ot_q;
endmodule

// File: tb/tb_temp_sense_sched.sv
// tb_temp_sense_sched: directed vectors plus multi-cycle sequences for the TSD sequencer
module tb_temp_sense_sched;
   logic       clk = 1'b0, arst = 1'b1, enable = 1'b0, sample_req = 1'b0;
   logic       tsd_done = 1'b0;
   logic [7:0] tsd_out = '0;
   logic       busy, tsd_clr, fresh_sample, failed_sample, over_temp;
   logic [7:0] degrees_c, degrees_c_avg;
   int         checks = 0, errors = 0, cyc = 0, rises = 0;
   logic       clr_d = 1'b0;

   typedef struct {
      logic [7:0] raw;
      logic [7:0] deg;
      logic [7:0] avg;
      logic       ot;
      bit         by_req;
   } vec_t;
   vec_t vecs [7];

   temp_sense_sched #(
      .PERIOD_CYCLES  (20'd100),
      .CLR_CYCLES     (4),
      .TIMEOUT_CYCLES (20'd50),
      .MAX_RETRY      (2)
   ) dut (
      .clk           (clk),
      .arst          (arst),
      .enable        (enable),
      .sample_req    (sample_req),
      .busy          (busy),
      .tsd_clr       (tsd_clr),
      .tsd_done      (tsd_done),
      .tsd_out       (tsd_out),
      .degrees_c     (degrees_c),
      .degrees_c_avg (degrees_c_avg),
      .fresh_sample  (fresh_sample),
      .failed_sample (failed_sample),
      .over_temp     (over_temp)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      clr_d <= tsd_clr;
      if (tsd_clr && !clr_d) rises <= rises + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_clr"}, tsd_clr, 0);
      chk({tag, "_deg"}, degrees_c, 0);
      chk({tag, "_avg"}, degrees_c_avg, 0);
      chk({tag, "_fresh"}, fresh_sample, 0);
      chk({tag, "_failed"}, failed_sample, 0);
      chk({tag, "_ot"}, over_temp, 0);
   endtask

   task automatic pulse_req();
      @(negedge clk) sample_req = 1'b1;
      @(negedge clk) sample_req = 1'b0;
   endtask

   // TSD model: answers 10 cycles after clr falls; returns on the negedge where fresh_sample is high
   task automatic convert(input logic [7:0] raw, input string tag);
      int n;
      n = 0;
      while (!tsd_clr && n < 400) begin @(negedge clk); n++; end
      chk({tag, "_clr_start"}, tsd_clr, 1);
      n = 0;
      while (tsd_clr && n < 300) begin @(negedge clk); n++; end
      chk({tag, "_clr_width"}, n, 4);
      repeat (9) @(negedge clk);
      tsd_out  = raw;
      tsd_done = 1'b1;
      @(negedge clk);
      n = 0;
      while (!fresh_sample && n < 20) begin @(negedge clk); n++; end
      chk({tag, "_fresh_latency"}, n, 3);
      tsd_done = 1'b0;
   endtask

   task automatic run_vec(input int i);
      string t;
      t = $sformatf("v%0d", i);
      if (vecs[i].by_req) pulse_req();
      convert(vecs[i].raw, t);
      chk({t, "_deg"}, degrees_c, vecs[i].deg);
      chk({t, "_avg"}, degrees_c_avg, vecs[i].avg);
      chk({t, "_ot"}, over_temp, vecs[i].ot);
      @(negedge clk);
      chk({t, "_fresh_drop"}, fresh_sample, 0);
      chk({t, "_idle"}, busy, 0);
   endtask

   initial begin
      int n, r0, e0;
      vecs[0] = '{8'd158, 8'd25, 8'd25, 1'b0, 1'b0};
      vecs[1] = '{8'd162, 8'd29, 8'd26, 1'b0, 1'b0};
      vecs[2] = '{8'd166, 8'd33, 8'd28, 1'b0, 1'b0};
      vecs[3] = '{8'd170, 8'd37, 8'd31, 1'b0, 1'b0};
      vecs[4] = '{8'd218, 8'd85, 8'd46, 1'b1, 1'b1};
      vecs[5] = '{8'd214, 8'd81, 8'd59, 1'b1, 1'b1};
      vecs[6] = '{8'd212, 8'd79, 8'd70, 1'b0, 1'b1};

      repeat (3) @(negedge clk);
      chk_zero("reset");
      arst   = 1'b0;
      enable = 1'b1;

      // periodic conversions (test plan 1, 2)
      for (int i = 0; i < 4; i++) run_vec(i);
      enable = 1'b0;

      // no done ever: two retries then failure
      pulse_req();
      for (int a = 0; a < 3; a++) begin
         n = 0;
         while (!tsd_clr && n < 100) begin @(negedge clk); n++; end
         chk($sformatf("t3_clr_seen%0d", a), tsd_clr, 1);
         n = 0;
         while (tsd_clr && n < 100) begin @(negedge clk); n++; end
         chk($sformatf("t3_clr_width%0d", a), n, 4);
         n = 0;
         while (!tsd_clr && !failed_sample && n < 200) begin @(negedge clk); n++; end
         chk($sformatf("t3_wait_cycles%0d", a), n, 50);
         chk($sformatf("t3_failed%0d", a), failed_sample, a == 2);
      end
      chk("t3_busy", busy, 0);
      chk("t3_deg_held", degrees_c, 37);
      chk("t3_avg_held", degrees_c_avg, 31);
      chk("t3_ot_held", over_temp, 0);
      r0 = rises;
      @(negedge clk);
      chk("t3_failed_pulse", failed_sample, 0);
      repeat (30) @(negedge clk);
      chk("t3_no_more_attempts", rises - r0, 0);

      // alarm hysteresis
      for (int i = 4; i < 7; i++) run_vec(i);

      // request collapsing and tick+req coincidence
      @(negedge clk);
      enable     = 1'b1;
      sample_req = 1'b1;
      e0 = cyc;
      r0 = rises;
      @(negedge clk) sample_req = 1'b0;
      fork
         convert(8'd150, "t5a");
         begin
            repeat (5) @(negedge clk);
            for (int k = 0; k < 3; k++) begin
               sample_req = 1'b1;
               @(negedge clk) sample_req = 1'b0;
               @(negedge clk);
            end
         end
      join
      chk("t5a_deg", degrees_c, 17);
      chk("t5a_avg", degrees_c_avg, 65);
      convert(8'd151, "t5b");
      chk("t5b_deg", degrees_c, 18);
      chk("t5b_avg", degrees_c_avg, 48);
      n = 0;
      while (cyc < e0 + 99 && n < 200) begin @(negedge clk); n++; end
      chk("t5_one_followup", rises - r0, 2);
      sample_req = 1'b1;
      @(negedge clk);
      sample_req = 1'b0;
      enable     = 1'b0;
      convert(8'd152, "t5c");
      chk("t5c_deg", degrees_c, 19);
      chk("t5c_avg", degrees_c_avg, 33);
      repeat (150) @(negedge clk);
      chk("t5_no_third", rises - r0, 3);

      // asynchronous reset during CLEAR, then during WAIT
      pulse_req();
      chk("t6_clr_before", tsd_clr, 1);
      #2 arst = 1'b1;
      #1 chk_zero("t6_clear_rst");
      @(negedge clk) arst = 1'b0;
      pulse_req();
      n = 0;
      while (tsd_clr && n < 50) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      chk("t6_busy_before", busy, 1);
      #2 arst = 1'b1;
      #1 chk_zero("t6_wait_rst");
      @(negedge clk) arst = 1'b0;
      pulse_req();
      convert(8'd143, "t6");
      chk("t6_deg", degrees_c, 10);
      chk("t6_avg_preload", degrees_c_avg, 10);
      chk("t6_ot", over_temp, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/temp_sense_sched.md
Name: temp_sense_sched

Overview:
- Sequencing controller for the on-die temperature sense diode (TSD) hard block.
- Issues periodic and on-demand conversions by pulsing the TSD clear input. Waits for conversion-done under a timeout, and retries on failure.
- Converts the raw code to Celsius and keeps a 4-sample running average.
- Drives an over-temperature alarm with hysteresis. Sits between the TSD primitive and the debug/monitor logic that consumes temperatures.

Parameters:
PERIOD_CYCLES, 20'd1048575, clk cycles between periodic conversion ticks (counter width 20)
CLR_CYCLES, 16, cycles tsd_clr is held high per conversion attempt (1..255)
TIMEOUT_CYCLES, 20'd524288, max cycles in WAIT for tsd_done before the attempt fails
MAX_RETRY, 2, extra attempts after a timeout before failed_sample is reported (0..3)
OFFSET_DEGREES, 8'd133, subtracted from raw TSD code to give degrees C
ALARM_HI, 8'd85, over_temp sets when degrees_c >= ALARM_HI
ALARM_LO, 8'd80, over_temp clears when degrees_c < ALARM_LO (ALARM_LO <= ALARM_HI)

Ports:
clk  in  1  system clock, < 80 MHz
arst  in  1  reset; asynchronous, active-high
enable  in  1  allows periodic ticks; when low the period counter holds at 0
sample_req  in  1  single-cycle request for an immediate conversion
busy  out  1  high whenever state != IDLE
tsd_clr  out  1  to TSD clr input
tsd_done  in  1  from TSD conversion done, asynchronous to clk
tsd_out  in  8  from TSD raw code, stable while tsd_done high
degrees_c  out  8  latest good sample, raw - OFFSET_DEGREES
degrees_c_avg  out  8  mean of last 4 good samples
fresh_sample  out  1  1-cycle pulse when degrees_c/degrees_c_avg update
failed_sample  out  1  1-cycle pulse when all attempts time out
over_temp  out  1  hysteretic alarm

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; counters 0.
  - pending flag 0; average history marked empty.
  - Reset mid-conversion aborts immediately; tsd_clr drops asynchronously.
- tsd_done passes through a 2-flop synchronizer; only the synchronized version is used.
- Period counter:
  - counts while enable is high; wraps at PERIOD_CYCLES-1 and raises a 1-cycle tick.
  - enable low resets the counter to 0.
- Pending flag:
  - set by a tick or sample_req; cleared on IDLE->CLEAR.
  - Tick and req in the same cycle give one pending.
  - Requests arriving while busy collapse into the single pending flag. That yields exactly one follow-up conversion, started after return to IDLE.
- FSM states: IDLE, CLEAR, WAIT, CAPTURE, REPORT.
  - IDLE: if pending (or tick/req this cycle), go to CLEAR with retry count 0.
  - CLEAR: tsd_clr = 1 for exactly CLR_CYCLES cycles, then go to WAIT with the timeout counter at 0.
  - WAIT: tsd_clr = 0.
    - Synchronized done high -> CAPTURE.
    - Counter reaching TIMEOUT_CYCLES-1 with retry < MAX_RETRY -> retry++, go to CLEAR.
    - Counter reaching TIMEOUT_CYCLES-1 with retry = MAX_RETRY -> failed_sample pulse, go to IDLE, data outputs held.
    - Done and timeout in the same cycle: done wins.
  - CAPTURE: register tsd_out into raw_q, then go to REPORT.
  - REPORT: update the data outputs, pulse fresh_sample, go to IDLE.
- Latency: fresh_sample rises 3 cycles after tsd_done first becomes high, assuming a clean edge (2 sync + CAPTURE).
- Arithmetic:
  - degrees_c = raw_q - OFFSET_DEGREES, 8-bit modulo (wraps; no saturation).
  - Average:
    - 4-entry shift history plus a 10-bit sum; degrees_c_avg = sum[9:2] (truncate).
    - The first good sample after reset preloads all 4 entries, so avg = that sample.
  - Alarm compares use the new degrees_c (not the average), unsigned. The alarm updates in the same cycle as fresh_sample.
  - Between ALARM_LO and ALARM_HI-1, over_temp holds its value.
- failed_sample never changes degrees_c, degrees_c_avg, over_temp or the history.
- fresh_sample and failed_sample are mutually exclusive and never occur on consecutive conversions without an intervening IDLE cycle.

Decomposition:
- Package temp_sense_pkg:
  - FSM state enum (3-bit encoding).
  - Width constants TS_W=8, TIMER_W=20, SUM_W=10.
  - Default OFFSET/ALARM constants, shared with temp-display blocks.
- Sub-module temp_avg4: history, preload-on-empty, running sum, avg output.
  - Inputs: clk, arst, load, sample[7:0].

Test Plan:
1. Reset, PERIOD_CYCLES=100, CLR_CYCLES=4, TIMEOUT_CYCLES=50, enable=1; TSD model asserts done with tsd_out=8'd158 10 cycles after clr falls -> tsd_clr high exactly 4 cycles; fresh_sample 3 cycles after done; degrees_c=25, degrees_c_avg=25.
2. Subsequent samples 8'd162, 8'd166, 8'd170 -> degrees_c 29, 33, 37; avg (25+25+25+29)>>2=26, then 28, then 31.
3. TSD never asserts done, MAX_RETRY=2 -> three 4-cycle clr pulses 50 WAIT cycles apart; one failed_sample; degrees_c unchanged; busy low afterwards.
4. Samples raw 218, 214, 212 (85, 81, 79 C) -> over_temp sets on 85, stays set at 81, clears at 79.
5. sample_req pulsed 3 times during a busy conversion and also coinciding with a tick -> exactly one extra conversion follows; no third.
6. arst asserted during WAIT with tsd_clr/busy active -> all outputs 0 immediately; after release, the first sample preloads avg (raw 143 -> degrees_c=10, avg=10).
